// File: rtl/aes_key_schedule.sv
// aes_key_schedule: iterative AES-128/192/256 key expansion.
// A start in IDLE loads the Nk cipher-key words into the word store in one edge.
// GEN then produces one schedule word per clock until word 4*(Nr+1)-1 is written.
// Round keys are read by index through a registered 128-bit port.
//
// Handshake: start is a single-cycle request sampled on every rising edge.
// In IDLE it is either accepted (busy rises on that edge) or rejected (err
// pulses on that edge). In GEN it is ignored. done pulses for exactly one
// cycle with ready rising at the same edge. ready stays high until the next
// accepted start.
module aes_key_schedule #(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_mode,
  input  logic [0:255] key_in,
  output logic         busy,
  output logic         done,
  output logic         ready,
  output logic         err,
  output logic [3:0]   nr,
  input  logic [3:0]   rk_idx,
  output logic [0:127] rk_out
);

  localparam int MAX_NK = MAX_KEY_BITS / 32;
  localparam int DEPTH  = 4 * (MAX_NK + 7);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [3:0] MAX_NK_W = 4'(MAX_NK);

  // FIPS-197 forward S-box.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GEN  = 1'b1
  } state_e;

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Control and output registers
  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic [3:0]       nr_q, nr_d;
  logic [3:0]       nk_q, nk_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic [2:0]       j_q, j_d;
  logic [7:0]       rcon_q, rcon_d;
  logic [0:127]     rk_out_q, rk_out_d;

  // Word store (not reset)
  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      mem_d [DEPTH];

  // Combinational helpers
  logic [3:0]       mode_nk;
  logic [3:0]       mode_nr;
  logic             mode_ok;
  logic             wr_key;
  logic             wr_gen;
  logic [31:0]      w_prev;
  logic [31:0]      w_old;
  logic [31:0]      temp;
  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] rd_base;

  // Decode requested key size; sizes above MAX_KEY_BITS are unsupported.
  always_comb begin
    mode_nk = 4'd0;
    mode_nr = 4'd0;
    case (key_mode)
      2'd0:    begin mode_nk = 4'd4; mode_nr = 4'd10; end
      2'd1:    begin mode_nk = 4'd6; mode_nr = 4'd12; end
      2'd2:    begin mode_nk = 4'd8; mode_nr = 4'd14; end
      default: begin mode_nk = 4'd0; mode_nr = 4'd0;  end
    endcase
    mode_ok = (key_mode != 2'd3) && (mode_nk <= MAX_NK_W);
  end

  // Schedule word datapath: temp derived from w[i-1] by phase j.
  always_comb begin
    w_prev   = mem_q[i_q - IDX_W'(1)];
    w_old    = mem_q[i_q - IDX_W'(nk_q)];
    last_idx = IDX_W'({nr_q, 2'b11});
    if (j_q == 3'd0) begin
      temp = sub_word(rot_word(w_prev)) ^ {rcon_q, 24'h0};
    end else if ((nk_q == 4'd8) && (j_q == 3'd4)) begin
      temp = sub_word(w_prev);
    end else begin
      temp = w_prev;
    end
  end

  // FSM next state: start acceptance/rejection and per-word generation.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ready_d = ready_q;
    err_d   = 1'b0;
    nr_d    = nr_q;
    nk_d    = nk_q;
    i_d     = i_q;
    j_d     = j_q;
    rcon_d  = rcon_q;
    wr_key  = 1'b0;
    wr_gen  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (mode_ok) begin
            wr_key  = 1'b1;
            nk_d    = mode_nk;
            nr_d    = mode_nr;
            i_d     = IDX_W'(mode_nk);
            j_d     = 3'd0;
            rcon_d  = 8'h01;
            ready_d = 1'b0;
            busy_d  = 1'b1;
            state_d = ST_GEN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_GEN: begin
        wr_gen = 1'b1;
        i_d    = i_q + IDX_W'(1);
        // j follows i mod Nk by wrapping instead of dividing
        j_d    = ({1'b0, j_q} == (nk_q - 4'd1)) ? 3'd0 : (j_q + 3'd1);
        if (j_q == 3'd0) begin
          rcon_d = xtime(rcon_q);
        end
        if (i_q == last_idx) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Store next value: parallel key load or one generated word.
  always_comb begin
    mem_d = mem_q;
    if (wr_key) begin
      for (int k = 0; k < MAX_NK; k++) begin
        if (k < int'(mode_nk)) begin
          mem_d[k] = key_in[32*k +: 32];
        end
      end
    end
    if (wr_gen) begin
      mem_d[i_q] = w_old ^ temp;
    end
  end

  // Read port: gated to zero unless the store is valid and the index is in range.
  always_comb begin
    rd_base = IDX_W'({rk_idx, 2'b00});
    if (ready_q && (rk_idx <= nr_q)) begin
      rk_out_d = {mem_q[rd_base], mem_q[rd_base + IDX_W'(1)],
                  mem_q[rd_base + IDX_W'(2)], mem_q[rd_base + IDX_W'(3)]};
    end else begin
      rk_out_d = '0;
    end
  end

  // Control state and registered outputs with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      nr_q     <= 4'd0;
      nk_q     <= 4'd0;
      i_q      <= '0;
      j_q      <= 3'd0;
      rcon_q   <= 8'h01;
      rk_out_q <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      nr_q     <= nr_d;
      nk_q     <= nk_d;
      i_q      <= i_d;
      j_q      <= j_d;
      rcon_q   <= rcon_d;
      rk_out_q <= rk_out_d;
    end
  end

  // Word store update; contents are meaningful only while ready is high.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign ready  = ready_q;
  assign err    = err_q;
  assign nr     = nr_q;
  assign rk_out = rk_out_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule using the FIPS-197 key expansion vectors.
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   key_mode;
  logic [0:255] key_in;
  logic         busy, done, ready, err;
  logic [3:0]   nr;
  logic [3:0]   rk_idx;
  logic [0:127] rk_out;

  // Second instance limited to 128-bit keys
  logic         s_start;
  logic [1:0]   s_key_mode;
  logic [0:255] s_key_in;
  logic         s_busy, s_done, s_ready, s_err;
  logic [3:0]   s_nr;
  logic [3:0]   s_rk_idx;
  logic [0:127] s_rk_out;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [0:255] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [0:255] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [0:255] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  localparam logic [0:127] RK128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] RK128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [0:127] RK128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [0:127] RK192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [0:127] RK256_0  = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [0:127] RK256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  // Clock and reset
  always #5 clk = ~clk;

  aes_key_schedule #(.MAX_KEY_BITS(256)) dut (
    .clk(clk), .rst(rst), .start(start), .key_mode(key_mode), .key_in(key_in),
    .busy(busy), .done(done), .ready(ready), .err(err), .nr(nr),
    .rk_idx(rk_idx), .rk_out(rk_out)
  );

  aes_key_schedule #(.MAX_KEY_BITS(128)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .key_mode(s_key_mode), .key_in(s_key_in),
    .busy(s_busy), .done(s_done), .ready(s_ready), .err(s_err), .nr(s_nr),
    .rk_idx(s_rk_idx), .rk_out(s_rk_out)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [1:0] mode, input logic [0:255] key);
    key_mode = mode;
    key_in   = key;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (done !== 1'b1 && edges < 200) begin
      tick();
      edges++;
    end
  endtask

  task automatic read_rk(input logic [3:0] idx);
    rk_idx = idx;
    tick();
  endtask

  // Scenarios
  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0; key_mode = 2'd0; key_in = '0; rk_idx = 4'd0;
    s_start = 1'b0; s_key_mode = 2'd0; s_key_in = '0; s_rk_idx = 4'd0;
    tick(); tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (nr !== 4'd0) begin n_fail++; $display("FAIL reset_nr: got %0d want 0", nr); end
    n_cmp++; if (rk_out !== 128'h0) begin n_fail++; $display("FAIL reset_rk_out: got %h want 0", rk_out); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_aes128();
    int edges;
    start_run(2'd0, K128);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL a128_busy: got %b want 1", busy); end
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL a128_ready_low: got %b want 0", ready); end
    wait_done(edges);
    n_cmp++; if (edges !== 40) begin n_fail++; $display("FAIL a128_edges: got %0d want 40", edges); end
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL a128_ready: got %b want 1", ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL a128_busy_end: got %b want 0", busy); end
    n_cmp++; if (nr !== 4'd10) begin n_fail++; $display("FAIL a128_nr: got %0d want 10", nr); end
    read_rk(4'd1);
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL a128_done_pulse: got %b want 0", done); end
    n_cmp++; if (rk_out !== RK128_1) begin n_fail++; $display("FAIL a128_rk1: got %h want %h", rk_out, RK128_1); end
    read_rk(4'd10);
    n_cmp++; if (rk_out !== RK128_10) begin n_fail++; $display("FAIL a128_rk10: got %h want %h", rk_out, RK128_10); end
    read_rk(4'd11);
    n_cmp++; if (rk_out !== 128'h0) begin n_fail++; $display("FAIL a128_rk11: got %h want 0", rk_out); end
    read_rk(4'd0);
    n_cmp++; if (rk_out !== RK128_0) begin n_fail++; $display("FAIL a128_rk0: got %h want %h", rk_out, RK128_0); end
  endtask

  task automatic test_aes192();
    int edges;
    start_run(2'd1, K192);
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL a192_ready_drop: got %b want 0", ready); end
    wait_done(edges);
    n_cmp++; if (edges !== 46) begin n_fail++; $display("FAIL a192_edges: got %0d want 46", edges); end
    n_cmp++; if (nr !== 4'd12) begin n_fail++; $display("FAIL a192_nr: got %0d want 12", nr); end
    read_rk(4'd12);
    n_cmp++; if (rk_out !== RK192_12) begin n_fail++; $display("FAIL a192_rk12: got %h want %h", rk_out, RK192_12); end
    read_rk(4'd13);
    n_cmp++; if (rk_out !== 128'h0) begin n_fail++; $display("FAIL a192_rk13: got %h want 0", rk_out); end
  endtask

  task automatic test_aes256();
    int edges;
    start_run(2'd2, K256);
    wait_done(edges);
    n_cmp++; if (edges !== 52) begin n_fail++; $display("FAIL a256_edges: got %0d want 52", edges); end
    n_cmp++; if (nr !== 4'd14) begin n_fail++; $display("FAIL a256_nr: got %0d want 14", nr); end
    read_rk(4'd14);
    n_cmp++; if (rk_out !== RK256_14) begin n_fail++; $display("FAIL a256_rk14: got %h want %h", rk_out, RK256_14); end
    read_rk(4'd0);
    n_cmp++; if (rk_out !== RK256_0) begin n_fail++; $display("FAIL a256_rk0: got %h want %h", rk_out, RK256_0); end
  endtask

  task automatic test_reject();
    start_run(2'd3, K128);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL rej_err: got %b want 1", err); end
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rej_ready: got %b want 1", ready); end
    n_cmp++; if (nr !== 4'd14) begin n_fail++; $display("FAIL rej_nr: got %0d want 14", nr); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rej_busy: got %b want 0", busy); end
    read_rk(4'd14);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rej_err_pulse: got %b want 0", err); end
    n_cmp++; if (rk_out !== RK256_14) begin n_fail++; $display("FAIL rej_store: got %h want %h", rk_out, RK256_14); end
  endtask

  task automatic test_max128();
    int edges;
    s_key_mode = 2'd2; s_key_in = K256; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    n_cmp++; if (s_err !== 1'b1) begin n_fail++; $display("FAIL max128_err: got %b want 1", s_err); end
    n_cmp++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL max128_busy: got %b want 0", s_busy); end
    n_cmp++; if (s_nr !== 4'd0) begin n_fail++; $display("FAIL max128_nr: got %0d want 0", s_nr); end
    s_key_mode = 2'd0; s_key_in = K128; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    edges = 0;
    while (s_done !== 1'b1 && edges < 200) begin
      tick();
      edges++;
    end
    n_cmp++; if (edges !== 40) begin n_fail++; $display("FAIL max128_edges: got %0d want 40", edges); end
    s_rk_idx = 4'd10;
    tick();
    n_cmp++; if (s_rk_out !== RK128_10) begin n_fail++; $display("FAIL max128_rk10: got %h want %h", s_rk_out, RK128_10); end
  endtask

  task automatic test_start_while_busy();
    int edges;
    start_run(2'd0, K128);
    repeat (10) tick();
    key_mode = 2'd2; key_in = K256; start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL busy_start_err: got %b want 0", err); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_start_busy: got %b want 1", busy); end
    wait_done(edges);
    n_cmp++; if (edges + 11 !== 40) begin n_fail++; $display("FAIL busy_start_edges: got %0d want 40", edges + 11); end
    n_cmp++; if (nr !== 4'd10) begin n_fail++; $display("FAIL busy_start_nr: got %0d want 10", nr); end
    read_rk(4'd1);
    n_cmp++; if (rk_out !== RK128_1) begin n_fail++; $display("FAIL busy_start_rk1: got %h want %h", rk_out, RK128_1); end
    read_rk(4'd10);
    n_cmp++; if (rk_out !== RK128_10) begin n_fail++; $display("FAIL busy_start_rk10: got %h want %h", rk_out, RK128_10); end
  endtask

  task automatic test_reset_mid();
    int edges;
    rk_idx = 4'd1;
    start_run(2'd0, K128);
    repeat (20) tick();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready: got %b want 0", ready); end
    n_cmp++; if (rk_out !== 128'h0) begin n_fail++; $display("FAIL rstmid_rk_out: got %h want 0", rk_out); end
    n_cmp++; if (nr !== 4'd0) begin n_fail++; $display("FAIL rstmid_nr: got %0d want 0", nr); end
    tick();
    rst = 1'b0;
    tick();
    read_rk(4'd1);
    n_cmp++; if (rk_out !== 128'h0) begin n_fail++; $display("FAIL rstmid_no_ready: got %h want 0", rk_out); end
    start_run(2'd0, K128);
    wait_done(edges);
    n_cmp++; if (edges !== 40) begin n_fail++; $display("FAIL rstmid_edges: got %0d want 40", edges); end
    read_rk(4'd1);
    n_cmp++; if (rk_out !== RK128_1) begin n_fail++; $display("FAIL rstmid_rk1: got %h want %h", rk_out, RK128_1); end
    read_rk(4'd10);
    n_cmp++; if (rk_out !== RK128_10) begin n_fail++; $display("FAIL rstmid_rk10: got %h want %h", rk_out, RK128_10); end
  endtask

  task automatic test_back_to_back();
    int edges;
    start_run(2'd0, K128);
    wait_done(edges);
    n_cmp++; if (edges !== 40) begin n_fail++; $display("FAIL b2b_first_edges: got %0d want 40", edges); end
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_done: got %b want 1", ready); end
    start_run(2'd2, K256);
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_drop: got %b want 0", ready); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b want 1", busy); end
    wait_done(edges);
    n_cmp++; if (edges !== 52) begin n_fail++; $display("FAIL b2b_edges: got %0d want 52", edges); end
    n_cmp++; if (nr !== 4'd14) begin n_fail++; $display("FAIL b2b_nr: got %0d want 14", nr); end
    read_rk(4'd14);
    n_cmp++; if (rk_out !== RK256_14) begin n_fail++; $display("FAIL b2b_rk14: got %h want %h", rk_out, RK256_14); end
    read_rk(4'd0);
    n_cmp++; if (rk_out !== RK256_0) begin n_fail++; $display("FAIL b2b_rk0: got %h want %h", rk_out, RK256_0); end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_reject();
    test_max128();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Iterative, mode-selectable AES key expansion engine that replaces the fixed ten-stage AES-128 subkey chain. It accepts a 128-, 192- or 256-bit cipher key and generates one 32-bit schedule word per clock into an internal round-key store. The cipher datapath then reads round keys by index through a registered port. It sits between the key-load interface and the round datapath and drives the round-count to the cipher controller.

## Interface
- MAX_KEY_BITS, 256: largest key size supported (128, 192 or 256). Store depth is 4*(MAX_NK+7) words, where MAX_NK = MAX_KEY_BITS/32.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  request expansion; sampled each rising edge.
- key_mode  in  2  key size: 0=AES-128 (Nk=4, Nr=10), 1=AES-192 (Nk=6, Nr=12), 2=AES-256 (Nk=8, Nr=14), 3=reserved.
- key_in  in  [0:255]  cipher key, left-aligned with bit 0 as MSB. Only bits [0:32*Nk-1] are used.
- busy  out  1  expansion in progress.
- done  out  1  one-cycle pulse when the last word has been written.
- ready  out  1  level; round-key store is valid.
- err  out  1  one-cycle pulse when a start request is rejected.
- nr  out  4  round count of the last accepted mode (10/12/14).
- rk_idx  in  4  round-key index to read, 0..Nr.
- rk_out  out  [0:127]  registered round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}.

## Operation
- The FSM has two states, IDLE and GEN. Reset puts it in IDLE with busy=0, done=0, ready=0, err=0, nr=0 and rk_out=0. The word store is not reset.
- **Start acceptance.** A start is accepted in IDLE when key_mode is not 3 and 32*Nk ≤ MAX_KEY_BITS. On that edge:
  - key words w[0..Nk-1] are written to the store in parallel;
  - i=Nk, the phase counter j=0, rcon=8'h01;
  - nr is latched;
  - ready and busy are set to 0 and 1;
  - the state moves to GEN.
- **Start rejection.** A start in IDLE with an invalid or unsupported mode pulses err. State, ready, nr and the store are unchanged.
- **Start while busy.** A start in GEN is ignored: no err, and the expansion continues.
- **Word generation (GEN).** Each edge writes w[i] = w[i-Nk] ^ temp, with temp = w[i-1] transformed by the phase counter j (j tracks i mod Nk without a divider, wrapping at Nk):
  - j==0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon = xtime(rcon). This gives the sequence 01,02,04,08,10,20,40,80,1b,36.
  - Nk==8 and j==4: temp = SubWord(temp).
  - Otherwise temp is used unchanged.
- **SubWord** applies the FIPS-197 S-box to each of the four bytes. The S-box is an internal 256-entry ROM and four lookups are made in parallel. RotWord is a left rotate by one byte.
- **Completion.** The last word is index 4*(Nr+1)-1, i.e. 43, 51 or 59. On the edge that writes it: state→IDLE, busy=0, ready=1, done=1 for exactly one cycle.
- **Read port.** On every edge rk_out <= (ready && rk_idx ≤ nr) ? store words 4*rk_idx..4*rk_idx+3 : 0.
- **Reset mid-expansion** immediately forces the IDLE reset values. The store contents are don't-care and ready stays 0 until a new expansion completes.

## Timing
- Generation edges after the start edge: 40 (AES-128), 46 (AES-192), 52 (AES-256).
- done and ready are visible after generation edge N. ready first rises in the same cycle as done.
- busy is high from the cycle after the start edge through the cycle containing the final write edge.
- Read latency is 1 cycle from rk_idx to rk_out. A start may be accepted in the same cycle that done is high, since the state is already IDLE. That start drops ready at the next edge.
- err appears 1 cycle after a rejected start edge.

## Test plan
- **AES-128.** Mode 0, key 2b7e151628aed2a6abf7158809cf4f3c → done 40 edges after start. rk_idx 1 gives a0fafe1788542cb123a339392a6c7605; rk_idx 10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; rk_idx 11 gives 0.
- **AES-192.** Mode 1, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → done after 46 edges, nr=12. rk_idx 12 gives e98ba06f448c773c8ecc720401002202.
- **AES-256.** Mode 2, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → done after 52 edges, nr=14. rk_idx 14 gives fe4890d1e6188d0b046df344706c631e; rk_idx 0 returns the first 128 key bits.
- **Rejection and ignore rules.**
  - Mode 3 start → err pulse, ready and nr unchanged.
  - With MAX_KEY_BITS=128, a mode 2 start → err pulse.
  - A start pulse mid-GEN → ignored, and the result still matches the first key.
- **Reset mid-expansion.** Assert rst at generation edge 20 → busy=0, ready=0, rk_out=0 immediately. A subsequent AES-128 run reproduces the first test's vectors.
- **Back-to-back runs.** Start an AES-256 run in the done cycle of an AES-128 run → ready drops next edge, and the new results are correct.
